// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch front end: reset vector, FSM encoding
// and the instruction-queue entry layout.
package cpu_pkg;

  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;
  localparam int unsigned IfqWidth       = 64;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFetch   = 2'd1,
    StDiscard = 2'd2
  } fetch_state_e;

  // Queue entry: instruction word in the upper half, NPC1 in the lower half.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] npc;
  } ifq_entry_t;

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Bundles the instruction-memory handshake and the FI/ID-side delivery/redirect signals.
interface ifetch_prefetch_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_npc;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_npc,
    input  mem_ack, mem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_npc,
    output mem_ack, mem_rdata, inst_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/ifq_fifo.sv
// DEPTH-entry synchronous instruction queue with flush; flush overrides push and pop.
module ifq_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push,
  input  logic                      pop,
  input  logic [IfqWidth-1:0]       wdata,
  output logic [IfqWidth-1:0]       rdata,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = PtrW + 1;

  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0]   count_q;
  logic [IfqWidth-1:0] mem_q [DEPTH];
  logic                do_push, do_pop;

  assign full    = (count_q == CountW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  // Storage is reset so the head reads as zero rather than X while empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CountW'(do_push) - CountW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: sequential prefetch over a req/ack memory port into a
// small queue, with back-pressure and redirects that may land on an outstanding fetch.
module ifetch_prefetch
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input logic               clk,
  input logic               reset,
  ifetch_prefetch_if.master bus
);

  localparam int unsigned CountW     = $clog2(DEPTH) + 1;
  localparam logic [31:0] ResetPcAln = {RESET_PC[31:2], 2'b00};

  fetch_state_e      state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       saved_pc_q, saved_pc_d;
  logic [31:0]       redir_pc;
  logic [31:0]       pc_plus4;
  logic              mem_req;
  logic              redirect_taken;
  logic              push, pop;
  logic              q_full, q_empty;
  logic [CountW-1:0] q_count;
  ifq_entry_t        head;
  ifq_entry_t        wentry;

  assign redir_pc       = {bus.redirect_pc[31:2], 2'b00};
  assign pc_plus4       = fetch_pc_q + 32'd4;
  assign redirect_taken = bus.redirect && (state_q != StIdle);
  assign pop            = !q_empty && bus.inst_ready && !redirect_taken;
  assign wentry         = '{inst: bus.mem_rdata, npc: pc_plus4};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    saved_pc_d = saved_pc_q;
    mem_req    = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        mem_req = (q_count < CountW'(DEPTH));
        if (redirect_taken) begin
          // A request the memory has seen but not answered must be drained first.
          if (mem_req && !bus.mem_ack) begin
            saved_pc_d = redir_pc;
            state_d    = StDiscard;
          end else begin
            fetch_pc_d = redir_pc;
          end
        end else if (mem_req && bus.mem_ack && !q_full) begin
          push       = 1'b1;
          fetch_pc_d = pc_plus4;
        end
      end
      StDiscard: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          fetch_pc_d = redirect_taken ? redir_pc : saved_pc_q;
          state_d    = StFetch;
        end else if (redirect_taken) begin
          saved_pc_d = redir_pc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= ResetPcAln;
      saved_pc_q <= ResetPcAln;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      saved_pc_q <= saved_pc_d;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_ifq (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_taken),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign bus.mem_req    = mem_req;
  assign bus.mem_addr   = fetch_pc_q;
  assign bus.inst_valid = !q_empty;
  assign bus.inst       = head.inst;
  assign bus.inst_npc   = head.npc;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch: a per-cycle vector table for streaming and
// back-pressure, then hand-written redirect, wrap and async-reset sequences.
module tb_ifetch_prefetch;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ifetch_prefetch_if bus ();

  ifetch_prefetch #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        c_inst;
    logic [31:0] e_inst;
    logic [31:0] e_npc;
  } vec_t;

  localparam int NumVec = 15;
  vec_t vecs [NumVec];

  function automatic vec_t mk(input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic c_inst,
                              input logic [31:0] e_inst, input logic [31:0] e_npc,
                              input logic ack, input logic [31:0] rdata, input logic ready);
    vec_t v;
    v.e_req = e_req;   v.e_addr = e_addr; v.e_valid = e_valid;
    v.c_inst = c_inst; v.e_inst = e_inst; v.e_npc = e_npc;
    v.ack = ack;       v.rdata = rdata;   v.ready = ready;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic ready,
                       input logic redir, input logic [31:0] rpc);
    bus.mem_ack     = ack;
    bus.mem_rdata   = rdata;
    bus.inst_ready  = ready;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    //       req addr   vld chk inst          npc     ack rdata         rdy
    vecs[0]  = mk(0, 32'h00, 0, 1, 32'h0,         32'h00, 0, 32'h0,         1);
    vecs[1]  = mk(1, 32'h00, 0, 0, 32'h0,         32'h00, 1, 32'h1000_0000, 1);
    vecs[2]  = mk(1, 32'h04, 1, 1, 32'h1000_0000, 32'h04, 1, 32'h1000_0004, 1);
    vecs[3]  = mk(1, 32'h08, 1, 1, 32'h1000_0004, 32'h08, 1, 32'h1000_0008, 1);
    vecs[4]  = mk(1, 32'h0C, 1, 1, 32'h1000_0008, 32'h0C, 0, 32'h0,         1);
    vecs[5]  = mk(1, 32'h0C, 0, 0, 32'h0,         32'h00, 1, 32'h1000_000C, 0);
    vecs[6]  = mk(1, 32'h10, 1, 1, 32'h1000_000C, 32'h10, 1, 32'h1000_0010, 0);
    vecs[7]  = mk(1, 32'h14, 1, 1, 32'h1000_000C, 32'h10, 1, 32'h1000_0014, 0);
    vecs[8]  = mk(1, 32'h18, 1, 1, 32'h1000_000C, 32'h10, 1, 32'h1000_0018, 0);
    vecs[9]  = mk(0, 32'h1C, 1, 1, 32'h1000_000C, 32'h10, 0, 32'h0,         0);
    vecs[10] = mk(0, 32'h1C, 1, 1, 32'h1000_000C, 32'h10, 0, 32'h0,         1);
    vecs[11] = mk(1, 32'h1C, 1, 1, 32'h1000_0010, 32'h14, 0, 32'h0,         1);
    vecs[12] = mk(1, 32'h1C, 1, 1, 32'h1000_0014, 32'h18, 0, 32'h0,         1);
    vecs[13] = mk(1, 32'h1C, 1, 1, 32'h1000_0018, 32'h1C, 0, 32'h0,         1);
    vecs[14] = mk(1, 32'h1C, 0, 0, 32'h0,         32'h00, 0, 32'h0,         1);

    @(negedge clk);
    @(negedge clk);
    chk("rst req",   32'(bus.mem_req),    32'd0);
    chk("rst addr",  bus.mem_addr,        32'h0);
    chk("rst valid", 32'(bus.inst_valid), 32'd0);
    chk("rst inst",  bus.inst,            32'h0);
    chk("rst npc",   bus.inst_npc,        32'h0);
    chk("rst state", 32'(dut.state_q),    32'(StIdle));
    reset = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      chk($sformatf("row%0d req", i),   32'(bus.mem_req),    32'(vecs[i].e_req));
      chk($sformatf("row%0d addr", i),  bus.mem_addr,        vecs[i].e_addr);
      chk($sformatf("row%0d valid", i), 32'(bus.inst_valid), 32'(vecs[i].e_valid));
      if (vecs[i].c_inst) begin
        chk($sformatf("row%0d inst", i), bus.inst,     vecs[i].e_inst);
        chk($sformatf("row%0d npc", i),  bus.inst_npc, vecs[i].e_npc);
      end
      drive(vecs[i].ack, vecs[i].rdata, vecs[i].ready, 1'b0, 32'h0);
      @(negedge clk);
    end

    // Redirect one cycle into a slow fetch: drain it in DISCARD, then restart at 0x100.
    chk("a0 req", 32'(bus.mem_req), 32'd1);
    chk("a0 addr", bus.mem_addr, 32'h1C);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
    @(negedge clk);
    chk("a2 state", 32'(dut.state_q), 32'(StDiscard));
    chk("a2 addr", bus.mem_addr, 32'h1C);
    chk("a2 req", 32'(bus.mem_req), 32'd1);
    chk("a2 valid", 32'(bus.inst_valid), 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("a3 addr", bus.mem_addr, 32'h1C);
    chk("a3 req", 32'(bus.mem_req), 32'd1);
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("a4 state", 32'(dut.state_q), 32'(StFetch));
    chk("a4 addr", bus.mem_addr, 32'h100);
    chk("a4 valid", 32'(bus.inst_valid), 32'd0);
    drive(1'b1, 32'h2000_0100, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("a5 valid", 32'(bus.inst_valid), 32'd1);
    chk("a5 inst", bus.inst, 32'h2000_0100);
    chk("a5 npc", bus.inst_npc, 32'h104);
    chk("a5 addr", bus.mem_addr, 32'h104);

    // Redirect coincident with ack: data dropped, no DISCARD, head not popped.
    drive(1'b1, 32'hBAD0_0000, 1'b1, 1'b1, 32'h200);
    @(negedge clk);
    chk("b1 state", 32'(dut.state_q), 32'(StFetch));
    chk("b1 addr", bus.mem_addr, 32'h200);
    chk("b1 valid", 32'(bus.inst_valid), 32'd0);

    // Two redirects inside one DISCARD: the later target wins.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
    @(negedge clk);
    chk("c1 state", 32'(dut.state_q), 32'(StDiscard));
    chk("c1 addr", bus.mem_addr, 32'h200);
    chk("c1 valid", 32'(bus.inst_valid), 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h400);
    @(negedge clk);
    chk("c2 state", 32'(dut.state_q), 32'(StDiscard));
    chk("c2 addr", bus.mem_addr, 32'h200);
    chk("c2 valid", 32'(bus.inst_valid), 32'd0);
    drive(1'b1, 32'hBAD1_1111, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("c3 state", 32'(dut.state_q), 32'(StFetch));
    chk("c3 addr", bus.mem_addr, 32'h400);
    chk("c3 valid", 32'(bus.inst_valid), 32'd0);

    // Unaligned redirect target is forced aligned; fetch at the top of memory wraps.
    drive(1'b1, 32'hBAD2_2222, 1'b1, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("d1 addr", bus.mem_addr, 32'hFFFF_FFFC);
    chk("d1 valid", 32'(bus.inst_valid), 32'd0);
    drive(1'b1, 32'h3000_0000, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("d2 addr", bus.mem_addr, 32'h0);
    chk("d2 valid", 32'(bus.inst_valid), 32'd1);
    chk("d2 inst", bus.inst, 32'h3000_0000);
    chk("d2 npc", bus.inst_npc, 32'h0);
    drive(1'b1, 32'h3000_0004, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("d3 addr", bus.mem_addr, 32'h4);
    chk("d3 inst", bus.inst, 32'h3000_0000);

    // Reset asserted mid-DISCARD must clear outputs without waiting for a clock edge.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h500);
    @(negedge clk);
    chk("e1 state", 32'(dut.state_q), 32'(StDiscard));
    chk("e1 addr", bus.mem_addr, 32'h4);
    chk("e1 valid", 32'(bus.inst_valid), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("e2 req", 32'(bus.mem_req), 32'd0);
    chk("e2 addr", bus.mem_addr, 32'h0);
    chk("e2 valid", 32'(bus.inst_valid), 32'd0);
    chk("e2 inst", bus.inst, 32'h0);
    chk("e2 npc", bus.inst_npc, 32'h0);
    chk("e2 state", 32'(dut.state_q), 32'(StIdle));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("e3 state", 32'(dut.state_q), 32'(StFetch));
    chk("e3 req", 32'(bus.mem_req), 32'd1);
    chk("e3 addr", bus.mem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
Instruction-fetch front end for the pipelined CPU. It generates sequential fetch addresses and fetches words from instruction memory over a req/ack handshake that may take several cycles. Fetched words are buffered in a small queue and delivered to the FI/ID pipeline register as instruction plus NPC1 (PC+4). It handles pipeline back-pressure and branch/jump redirects, including redirects that arrive while a fetch is still outstanding.

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  reset, asynchronous, active-low.
mem_req  out  1  fetch request to instruction memory.
mem_addr  out  32  fetch address; word aligned.
mem_ack  in  1  fetch complete; mem_rdata valid in this cycle.
mem_rdata  in  32  fetched instruction word.
inst_valid  out  1  queue head holds a valid instruction.
inst_ready  in  1  FI/ID register accepts the head this cycle (0 = stall).
inst  out  32  head instruction.
inst_npc  out  32  head fetch address + 4.
redirect  in  1  PCSrc taken; flush and restart fetch.
redirect_pc  in  32  new fetch target.

Behaviour:
- While reset is low: state=IDLE, fetch_pc=RESET_PC, count=0, mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst=0, inst_npc=0.
- FSM states are IDLE, FETCH and DISCARD.
  - IDLE: on the first clock after reset release, go to FETCH; mem_req=0.
  - FETCH: mem_req=1 whenever count<DEPTH; mem_addr=fetch_pc.
  - DISCARD: mem_req=1 and mem_addr=old fetch_pc until mem_ack.
- Handshake rules: at most one outstanding request. Once mem_req is high without mem_ack, mem_req and mem_addr hold stable until mem_ack. Ack latency is any value ≥0 cycles after the req cycle (ack in the same cycle as req is legal).
- Accepted fetch (FETCH, mem_ack=1, no redirect):
  - push {mem_rdata, fetch_pc+4} into the queue;
  - fetch_pc <= fetch_pc+4, wrapping modulo 2^32.
- Latency: ack in cycle N gives inst_valid=1 in cycle N+1. With zero-wait memory and no stall, throughput is 1 instruction per cycle.
- Pop: when inst_valid && inst_ready, the head advances. Push and pop in the same cycle leave count unchanged.
- Full (count==DEPTH): mem_req=0 in FETCH; a request is never abandoned. A pop at full re-enables mem_req in the next cycle.
- Empty: inst_valid=0. inst/inst_npc are don't-care but must not be X after reset.
- Redirect (any state except IDLE) has priority over push and pop:
  - queue flushed; count=0 next cycle; inst_valid=0 next cycle;
  - an inst_ready in the same cycle is ignored.
- Redirect when no request is outstanding, or when mem_ack=1 in the same cycle: the ack data is dropped, fetch_pc <= redirect_pc, and the FSM stays in FETCH.
- Redirect while a request is outstanding with mem_ack=0:
  - saved_pc <= redirect_pc; go to DISCARD;
  - on the ack, drop the data, set fetch_pc <= saved_pc, and return to FETCH.
- Redirect during DISCARD: saved_pc is overwritten (the last redirect wins) and the queue stays empty.
- mem_rdata is never written into the queue while in DISCARD.
- Reset asserted mid-operation returns everything to the reset values immediately. The memory is required to abandon its request on reset.
- fetch_pc[1:0] and redirect_pc[1:0] are forced to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - the RESET_PC default;
  - the FSM state encoding (IDLE=2'd0, FETCH=2'd1, DISCARD=2'd2);
  - the ifq entry width constant (64).
- One sub-module, ifq_fifo: a DEPTH×64 synchronous FIFO with flush, push, pop, count, full and empty, and the same async active-low reset.
- The FSM, fetch_pc and saved_pc live in ifetch_prefetch.

Test Plan:
- Reset release, zero-wait memory, inst_ready=1 → mem_addr sequence 0,4,8,…; inst_valid first high 2 cycles after reset release; inst_npc = addr+4 in order.
- inst_ready=0 held, zero-wait memory, DEPTH=4 → exactly 4 acks accepted, then mem_req=0. Raising inst_ready pops 4 entries in order, and mem_req returns high the cycle after the first pop.
- 3-cycle ack latency, redirect to 0x100 in the cycle after req → FSM enters DISCARD; mem_addr is held until ack; the ack data is not delivered; the next mem_addr is 0x100.
- Redirect to 0x200 in the same cycle as mem_ack → the ack data is dropped, the next mem_addr is 0x200, and there is no DISCARD cycle.
- Two redirects (0x300 then 0x400) during one DISCARD → the next fetch is at 0x400 and the queue stays empty throughout.
- fetch_pc=0xFFFF_FFFC accepted → the entry has inst_npc=0, and the next mem_addr is 0x0000_0000. Reset asserted mid-DISCARD → all outputs go to reset values asynchronously.
